// File: rtl/axi_pad_pkg.sv
// Shared definitions for the AXI read/write latency padders: FSM states, the
// "keep current pad target" code, default AXI channel structs and helpers.
package axi_pad_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } pad_state_e;

    localparam logic [31:0] PadKeep = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [0:0]  user;
    } axi_ax_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } axi_w_chan_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
        logic [0:0] user;
    } axi_b_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } axi_r_chan_t;

    typedef struct packed {
        axi_ax_chan_t aw;
        logic         aw_valid;
        axi_w_chan_t  w;
        logic         w_valid;
        logic         b_ready;
        axi_ax_chan_t ar;
        logic         ar_valid;
        logic         r_ready;
    } axi_req_t;

    typedef struct packed {
        logic        aw_ready;
        logic        w_ready;
        axi_b_chan_t b;
        logic        b_valid;
        logic        ar_ready;
        axi_r_chan_t r;
        logic        r_valid;
    } axi_resp_t;

    // The cycle counter sticks at all-ones instead of wrapping to zero.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == PadKeep) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/axi_bus_if.sv
// Plain AXI4 bus bundle (subset of fields carried by the padders).
interface AXI_BUS;
    logic [3:0]  aw_id;
    logic [31:0] aw_addr;
    logic [7:0]  aw_len;
    logic        aw_valid;
    logic        aw_ready;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        w_last;
    logic        w_valid;
    logic        w_ready;
    logic [3:0]  b_id;
    logic [1:0]  b_resp;
    logic        b_valid;
    logic        b_ready;
    logic [3:0]  ar_id;
    logic [31:0] ar_addr;
    logic [7:0]  ar_len;
    logic        ar_valid;
    logic        ar_ready;
    logic [3:0]  r_id;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
    logic        r_valid;
    logic        r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_valid, input aw_ready,
        output w_data, w_strb, w_last, w_valid, input w_ready,
        input b_id, b_resp, b_valid, output b_ready,
        output ar_id, ar_addr, ar_len, ar_valid, input ar_ready,
        input r_id, r_data, r_resp, r_last, r_valid, output r_ready
    );

    modport Slave (
        input aw_id, aw_addr, aw_len, aw_valid, output aw_ready,
        input w_data, w_strb, w_last, w_valid, output w_ready,
        output b_id, b_resp, b_valid, input b_ready,
        input ar_id, ar_addr, ar_len, ar_valid, output ar_ready,
        output r_id, r_data, r_resp, r_last, r_valid, input r_ready
    );
endinterface

// File: rtl/axi_pad_write_intf.sv
// AXI_BUS flavour of the write padder: maps bus signals onto the struct ports,
// with user fields tied to zero (the bus carries none).
module axi_pad_write_intf
    import axi_pad_pkg::*;
#(
    parameter logic [31:0] PadCycles  = 32'd0,
    parameter bit          PadDynamic = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    AXI_BUS.Slave       slv,
    AXI_BUS.Master      mst,
    input  logic [31:0] pad_cycles_i,
    output logic [31:0] pad_cycles_o
);

    axi_req_t  w_slv_req;
    axi_req_t  w_mst_req;
    axi_resp_t w_slv_resp;
    axi_resp_t w_mst_resp;
    logic      w_unused;

    assign w_slv_req.aw       = '{id: slv.aw_id, addr: slv.aw_addr, len: slv.aw_len, user: 1'b0};
    assign w_slv_req.aw_valid = slv.aw_valid;
    assign w_slv_req.w        = '{data: slv.w_data, strb: slv.w_strb, last: slv.w_last};
    assign w_slv_req.w_valid  = slv.w_valid;
    assign w_slv_req.b_ready  = slv.b_ready;
    assign w_slv_req.ar       = '{id: slv.ar_id, addr: slv.ar_addr, len: slv.ar_len, user: 1'b0};
    assign w_slv_req.ar_valid = slv.ar_valid;
    assign w_slv_req.r_ready  = slv.r_ready;

    assign slv.aw_ready = w_slv_resp.aw_ready;
    assign slv.w_ready  = w_slv_resp.w_ready;
    assign slv.b_id     = w_slv_resp.b.id;
    assign slv.b_resp   = w_slv_resp.b.resp;
    assign slv.b_valid  = w_slv_resp.b_valid;
    assign slv.ar_ready = w_slv_resp.ar_ready;
    assign slv.r_id     = w_slv_resp.r.id;
    assign slv.r_data   = w_slv_resp.r.data;
    assign slv.r_resp   = w_slv_resp.r.resp;
    assign slv.r_last   = w_slv_resp.r.last;
    assign slv.r_valid  = w_slv_resp.r_valid;

    assign mst.aw_id    = w_mst_req.aw.id;
    assign mst.aw_addr  = w_mst_req.aw.addr;
    assign mst.aw_len   = w_mst_req.aw.len;
    assign mst.aw_valid = w_mst_req.aw_valid;
    assign mst.w_data   = w_mst_req.w.data;
    assign mst.w_strb   = w_mst_req.w.strb;
    assign mst.w_last   = w_mst_req.w.last;
    assign mst.w_valid  = w_mst_req.w_valid;
    assign mst.b_ready  = w_mst_req.b_ready;
    assign mst.ar_id    = w_mst_req.ar.id;
    assign mst.ar_addr  = w_mst_req.ar.addr;
    assign mst.ar_len   = w_mst_req.ar.len;
    assign mst.ar_valid = w_mst_req.ar_valid;
    assign mst.r_ready  = w_mst_req.r_ready;

    assign w_mst_resp.aw_ready = mst.aw_ready;
    assign w_mst_resp.w_ready  = mst.w_ready;
    assign w_mst_resp.b        = '{id: mst.b_id, resp: mst.b_resp, user: 1'b0};
    assign w_mst_resp.b_valid  = mst.b_valid;
    assign w_mst_resp.ar_ready = mst.ar_ready;
    assign w_mst_resp.r        = '{id: mst.r_id, data: mst.r_data, resp: mst.r_resp, last: mst.r_last};
    assign w_mst_resp.r_valid  = mst.r_valid;

    // User fields have no home on the bus side.
    assign w_unused = ^{w_mst_req.aw.user, w_mst_req.ar.user, w_slv_resp.b.user};

    axi_pad_write #(
        .PadCycles  (PadCycles),
        .PadDynamic (PadDynamic)
    ) i_pad (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .slv_req_i    (w_slv_req),
        .slv_resp_o   (w_slv_resp),
        .mst_req_o    (w_mst_req),
        .mst_resp_i   (w_mst_resp),
        .pad_cycles_i (pad_cycles_i),
        .pad_cycles_o (pad_cycles_o)
    );

endmodule

// File: rtl/axi_pad_write.sv
// AXI4 write-path latency padder: one write in flight, B released to the
// upstream master no earlier than pad_cycles after the AW handshake.
module axi_pad_write
    import axi_pad_pkg::*;
#(
    parameter logic [31:0] PadCycles  = 32'd0,
    parameter bit          PadDynamic = 1'b0,
    parameter type         req_t      = axi_req_t,
    parameter type         resp_t     = axi_resp_t,
    parameter type         b_chan_t   = axi_b_chan_t
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  req_t        slv_req_i,
    output resp_t       slv_resp_o,
    output req_t        mst_req_o,
    input  resp_t       mst_resp_i,
    input  logic [31:0] pad_cycles_i,
    output logic [31:0] pad_cycles_o
);

    pad_state_e  r_state;
    pad_state_e  w_state_next;
    logic [31:0] r_counter;
    logic [31:0] w_counter_next;
    logic [31:0] r_pad_cycles;
    logic [31:0] w_pad_dyn;
    logic [31:0] w_pad_next;
    b_chan_t     r_b;
    b_chan_t     w_b_next;
    logic        w_b_valid;

    assign pad_cycles_o = r_pad_cycles;

    // FSM next state, counter/pad updates and channel gating.
    always_comb begin
        w_state_next   = r_state;
        w_counter_next = r_counter;
        w_pad_dyn      = r_pad_cycles;
        w_b_next       = r_b;
        w_b_valid      = 1'b0;
        mst_req_o      = slv_req_i;
        slv_resp_o     = mst_resp_i;
        mst_req_o.b_ready = 1'b0;
        slv_resp_o.b      = r_b;
        case (r_state)
            IDLE: begin
                if (slv_req_i.aw_valid && mst_resp_i.aw_ready) begin
                    w_counter_next = 32'd1;
                    w_state_next   = BUSY;
                end else begin
                    w_counter_next = 32'd0;
                    w_state_next   = IDLE;
                end
            end
            BUSY: begin
                mst_req_o.aw_valid  = 1'b0;
                slv_resp_o.aw_ready = 1'b0;
                mst_req_o.b_ready   = 1'b1;
                w_counter_next      = sat_inc(r_counter);
                // Dynamic mode stretches the target to cover the slowest write seen.
                if (PadDynamic && (sat_inc(r_counter) > r_pad_cycles)) begin
                    w_pad_dyn = sat_inc(r_counter);
                end else begin
                    w_pad_dyn = r_pad_cycles;
                end
                if (mst_resp_i.b_valid) begin
                    w_b_next     = mst_resp_i.b;
                    w_state_next = HOLD;
                end else begin
                    w_state_next = BUSY;
                end
            end
            HOLD: begin
                mst_req_o.aw_valid  = 1'b0;
                slv_resp_o.aw_ready = 1'b0;
                w_b_valid           = (r_counter >= r_pad_cycles);
                if (w_b_valid && slv_req_i.b_ready) begin
                    w_counter_next = 32'd0;
                    w_state_next   = IDLE;
                end else begin
                    w_counter_next = sat_inc(r_counter);
                    w_state_next   = HOLD;
                end
            end
            default: begin
                w_counter_next = 32'd0;
                w_state_next   = IDLE;
            end
        endcase
        slv_resp_o.b_valid = w_b_valid;
        // An explicit programming value always beats the dynamic update.
        w_pad_next = (pad_cycles_i != PadKeep) ? pad_cycles_i : w_pad_dyn;
    end

    // State, counter, pad target and captured B registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= IDLE;
            r_counter    <= 32'd0;
            r_pad_cycles <= PadCycles;
            r_b          <= '0;
        end else begin
            r_state      <= w_state_next;
            r_counter    <= w_counter_next;
            r_pad_cycles <= w_pad_next;
            r_b          <= w_b_next;
        end
    end

endmodule

// File: tb/tb_axi_pad_write.sv
// Directed bench for axi_pad_write: a static-pad instance on struct ports and a
// dynamic-pad instance behind the AXI_BUS wrapper, driven with the same traffic.
module tb_axi_pad_write;
    import axi_pad_pkg::*;

    localparam logic [31:0] PadReset = 32'd10;

    logic        clk = 1'b0;
    logic        rst_ni;
    axi_req_t    slv_req;
    axi_resp_t   mst_resp;
    axi_resp_t   slv_resp0;
    axi_req_t    mst_req0;
    logic [31:0] pad_i;
    logic [31:0] pad0;
    logic [31:0] pad1;
    int          total = 0;
    int          bad = 0;

    AXI_BUS bus_slv ();
    AXI_BUS bus_mst ();

    always #5 clk = ~clk;

    axi_pad_write #(.PadCycles(PadReset), .PadDynamic(1'b0)) dut0 (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .slv_req_i    (slv_req),
        .slv_resp_o   (slv_resp0),
        .mst_req_o    (mst_req0),
        .mst_resp_i   (mst_resp),
        .pad_cycles_i (pad_i),
        .pad_cycles_o (pad0)
    );

    axi_pad_write_intf #(.PadCycles(PadReset), .PadDynamic(1'b1)) dut1 (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .slv          (bus_slv),
        .mst          (bus_mst),
        .pad_cycles_i (pad_i),
        .pad_cycles_o (pad1)
    );

    assign bus_slv.aw_id    = slv_req.aw.id;
    assign bus_slv.aw_addr  = slv_req.aw.addr;
    assign bus_slv.aw_len   = slv_req.aw.len;
    assign bus_slv.aw_valid = slv_req.aw_valid;
    assign bus_slv.w_data   = slv_req.w.data;
    assign bus_slv.w_strb   = slv_req.w.strb;
    assign bus_slv.w_last   = slv_req.w.last;
    assign bus_slv.w_valid  = slv_req.w_valid;
    assign bus_slv.b_ready  = slv_req.b_ready;
    assign bus_slv.ar_id    = slv_req.ar.id;
    assign bus_slv.ar_addr  = slv_req.ar.addr;
    assign bus_slv.ar_len   = slv_req.ar.len;
    assign bus_slv.ar_valid = slv_req.ar_valid;
    assign bus_slv.r_ready  = slv_req.r_ready;
    assign bus_mst.aw_ready = mst_resp.aw_ready;
    assign bus_mst.w_ready  = mst_resp.w_ready;
    assign bus_mst.b_id     = mst_resp.b.id;
    assign bus_mst.b_resp   = mst_resp.b.resp;
    assign bus_mst.b_valid  = mst_resp.b_valid;
    assign bus_mst.ar_ready = mst_resp.ar_ready;
    assign bus_mst.r_id     = mst_resp.r.id;
    assign bus_mst.r_data   = mst_resp.r.data;
    assign bus_mst.r_resp   = mst_resp.r.resp;
    assign bus_mst.r_last   = mst_resp.r.last;
    assign bus_mst.r_valid  = mst_resp.r_valid;

    task automatic set_pad(input logic [31:0] v);
        @(negedge clk);
        pad_i = v;
        @(negedge clk);
        pad_i = PadKeep;
    endtask

    // One write: AW at cycle 0, downstream B at cycle lat; records what the slave side sees.
    task automatic txn(input int lat, input int wait_rdy, input int pulse_k,
                       input logic [31:0] pulse_val, input logic aw_hold,
                       input logic [3:0] id, input logic [1:0] resp,
                       output int first_k, output int first1, output int hs_k,
                       output int aw_leak, output int unstable,
                       output logic [5:0] b_seen, output logic aw_acc);
        first_k = -1; first1 = -1; hs_k = -1; aw_leak = 0; unstable = 0; b_seen = 6'd0;
        @(negedge clk);
        slv_req.aw_valid  = 1'b1;
        slv_req.aw.id     = id;
        slv_req.b_ready   = 1'b0;
        mst_resp.aw_ready = 1'b1;
        pad_i = PadKeep;
        #1;
        aw_acc = slv_resp0.aw_ready & mst_req0.aw_valid;
        for (int k = 1; k <= 80 && hs_k < 0; k++) begin
            @(negedge clk);
            slv_req.aw_valid = aw_hold;
            mst_resp.b_valid = (k == lat);
            mst_resp.b.id    = (k == lat) ? id : 4'h0;
            mst_resp.b.resp  = (k == lat) ? resp : 2'b00;
            pad_i = (k == pulse_k) ? pulse_val : PadKeep;
            slv_req.b_ready = (wait_rdy == 0) || (first_k >= 0 && k >= first_k + wait_rdy);
            #1;
            if (slv_resp0.aw_ready || mst_req0.aw_valid) aw_leak++;
            if (bus_slv.b_valid && first1 < 0) first1 = k;
            if (slv_resp0.b_valid) begin
                if (first_k < 0) begin
                    first_k = k;
                    b_seen = {slv_resp0.b.id, slv_resp0.b.resp};
                end else if ({slv_resp0.b.id, slv_resp0.b.resp} != b_seen) begin
                    unstable++;
                end
                if (slv_req.b_ready) hs_k = k;
            end else if (first_k >= 0) begin
                unstable++;
            end
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        slv_req = '0;
        mst_resp = '0;
        pad_i = PadKeep;
        slv_req.aw_valid = 1'b1;
        mst_resp.aw_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++; if (slv_resp0.b_valid !== 1'b0) begin bad++; $display("FAIL rst_bvalid: got %0b want 0", slv_resp0.b_valid); end
        total++; if (mst_req0.b_ready !== 1'b0) begin bad++; $display("FAIL rst_bready: got %0b want 0", mst_req0.b_ready); end
        total++; if (pad0 !== 32'd10) begin bad++; $display("FAIL rst_pad0: got %0d want 10", pad0); end
        total++; if (pad1 !== 32'd10) begin bad++; $display("FAIL rst_pad1: got %0d want 10", pad1); end
        total++; if (mst_req0.aw_valid !== 1'b1 || slv_resp0.aw_ready !== 1'b1) begin bad++; $display("FAIL rst_aw_pass: got %0b/%0b want 1/1", mst_req0.aw_valid, slv_resp0.aw_ready); end
        @(negedge clk);
        slv_req.aw_valid = 1'b0;
        rst_ni = 1'b1;
    endtask

    task automatic test_passthrough();
        @(negedge clk);
        slv_req.ar.addr = 32'h0000_1000;
        slv_req.ar_valid = 1'b1;
        slv_req.w.data = 32'hDEAD_BEEF;
        slv_req.w_valid = 1'b1;
        mst_resp.r.data = 32'hCAFE_F00D;
        mst_resp.r_valid = 1'b1;
        #1;
        total++; if (mst_req0.ar.addr !== 32'h0000_1000) begin bad++; $display("FAIL pass_ar: got %h want 00001000", mst_req0.ar.addr); end
        total++; if (mst_req0.w.data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL pass_w: got %h want deadbeef", mst_req0.w.data); end
        total++; if (slv_resp0.r.data !== 32'hCAFE_F00D) begin bad++; $display("FAIL pass_r: got %h want cafef00d", slv_resp0.r.data); end
        total++; if (bus_mst.ar_addr !== 32'h0000_1000 || bus_slv.r_data !== 32'hCAFE_F00D) begin bad++; $display("FAIL pass_bus: got %h/%h want 00001000/cafef00d", bus_mst.ar_addr, bus_slv.r_data); end
        @(negedge clk);
        slv_req.ar_valid = 1'b0;
        slv_req.w_valid = 1'b0;
        mst_resp.r_valid = 1'b0;
    endtask

    task automatic test_pad10();
        int f, f1, hs, leak, unst; logic [5:0] bs; logic acc;
        txn(3, 0, -1, PadKeep, 1'b0, 4'h5, 2'b10, f, f1, hs, leak, unst, bs, acc);
        total++; if (acc !== 1'b1) begin bad++; $display("FAIL p10_aw_accept: got %0b want 1", acc); end
        total++; if (f != 10) begin bad++; $display("FAIL p10_bvalid_cycle: got %0d want 10", f); end
        total++; if (hs != 10) begin bad++; $display("FAIL p10_handshake: got %0d want 10", hs); end
        total++; if (bs !== {4'h5, 2'b10}) begin bad++; $display("FAIL p10_payload: got %h want %h", bs, {4'h5, 2'b10}); end
        total++; if (leak != 0) begin bad++; $display("FAIL p10_aw_blocked: got %0d want 0", leak); end
        total++; if (pad0 !== 32'd10) begin bad++; $display("FAIL p10_pad: got %0d want 10", pad0); end
        total++; if (f1 != 10) begin bad++; $display("FAIL p10_dyn_bvalid: got %0d want 10", f1); end
    endtask

    task automatic test_dynamic();
        int f, f1, hs, leak, unst; logic [5:0] bs; logic acc;
        set_pad(32'd2);
        txn(7, 0, -1, PadKeep, 1'b0, 4'hA, 2'b00, f, f1, hs, leak, unst, bs, acc);
        total++; if (f != 8) begin bad++; $display("FAIL dyn_static_bvalid: got %0d want 8", f); end
        total++; if (f1 != 8) begin bad++; $display("FAIL dyn_grow_bvalid: got %0d want 8", f1); end
        total++; if (pad0 !== 32'd2) begin bad++; $display("FAIL dyn_static_pad: got %0d want 2", pad0); end
        total++; if (pad1 !== 32'd8) begin bad++; $display("FAIL dyn_grow_pad: got %0d want 8", pad1); end
    endtask

    task automatic test_min_latency();
        int f, f1, hs, leak, unst; logic [5:0] bs; logic acc;
        set_pad(32'd0);
        txn(1, 0, -1, PadKeep, 1'b0, 4'h7, 2'b11, f, f1, hs, leak, unst, bs, acc);
        total++; if (f != 2) begin bad++; $display("FAIL p0_bvalid_cycle: got %0d want 2", f); end
        total++; if (bs !== {4'h7, 2'b11}) begin bad++; $display("FAIL p0_payload: got %h want %h", bs, {4'h7, 2'b11}); end
    endtask

    task automatic test_pad_pulse();
        int f, f1, hs, leak, unst; logic [5:0] bs; logic acc;
        set_pad(32'd10);
        txn(5, 0, 2, 32'd20, 1'b0, 4'h1, 2'b01, f, f1, hs, leak, unst, bs, acc);
        total++; if (f != 20) begin bad++; $display("FAIL pulse_bvalid_cycle: got %0d want 20", f); end
        repeat (3) @(negedge clk);
        #1;
        total++; if (pad0 !== 32'd20) begin bad++; $display("FAIL pulse_pad_kept: got %0d want 20", pad0); end
        total++; if (pad1 !== 32'd20) begin bad++; $display("FAIL pulse_pad_kept_dyn: got %0d want 20", pad1); end
    endtask

    task automatic test_back_to_back();
        int f, f1, hs, leak, unst; logic [5:0] bs; logic acc;
        set_pad(32'd3);
        txn(2, 5, -1, PadKeep, 1'b1, 4'h9, 2'b01, f, f1, hs, leak, unst, bs, acc);
        total++; if (f != 3) begin bad++; $display("FAIL hold_bvalid_cycle: got %0d want 3", f); end
        total++; if (hs != 8) begin bad++; $display("FAIL hold_handshake: got %0d want 8", hs); end
        total++; if (unst != 0) begin bad++; $display("FAIL hold_stable: got %0d want 0", unst); end
        total++; if (leak != 0) begin bad++; $display("FAIL hold_aw_blocked: got %0d want 0", leak); end
        txn(1, 0, -1, PadKeep, 1'b0, 4'h3, 2'b11, f, f1, hs, leak, unst, bs, acc);
        total++; if (acc !== 1'b1) begin bad++; $display("FAIL b2b_aw_accept: got %0b want 1", acc); end
        total++; if (f != 3) begin bad++; $display("FAIL b2b_bvalid_cycle: got %0d want 3", f); end
        total++; if (bs !== {4'h3, 2'b11}) begin bad++; $display("FAIL b2b_payload: got %h want %h", bs, {4'h3, 2'b11}); end
    endtask

    task automatic test_reset_hold();
        int replay = 0;
        set_pad(32'd5);
        @(negedge clk);
        slv_req.aw_valid = 1'b1;
        slv_req.aw.id = 4'h6;
        slv_req.b_ready = 1'b0;
        mst_resp.aw_ready = 1'b1;
        @(negedge clk);
        slv_req.aw_valid = 1'b0;
        mst_resp.b_valid = 1'b1;
        mst_resp.b.id = 4'h6;
        repeat (4) begin
            @(negedge clk);
            mst_resp.b_valid = 1'b0;
        end
        slv_req.ar.addr = 32'hA5A5_0000;
        slv_req.ar_valid = 1'b1;
        mst_resp.r.data = 32'h1234_5678;
        mst_resp.r_valid = 1'b1;
        slv_req.aw_valid = 1'b1;
        #1;
        total++; if (slv_resp0.b_valid !== 1'b1 || slv_resp0.aw_ready !== 1'b0) begin bad++; $display("FAIL rsth_pre: got %0b/%0b want 1/0", slv_resp0.b_valid, slv_resp0.aw_ready); end
        rst_ni = 1'b0;
        #1;
        total++; if (slv_resp0.b_valid !== 1'b0 || bus_slv.b_valid !== 1'b0) begin bad++; $display("FAIL rsth_bvalid: got %0b/%0b want 0/0", slv_resp0.b_valid, bus_slv.b_valid); end
        total++; if (slv_resp0.aw_ready !== 1'b1 || mst_req0.aw_valid !== 1'b1) begin bad++; $display("FAIL rsth_idle: got %0b/%0b want 1/1", slv_resp0.aw_ready, mst_req0.aw_valid); end
        total++; if (pad0 !== 32'd10 || pad1 !== 32'd10) begin bad++; $display("FAIL rsth_pad: got %0d/%0d want 10/10", pad0, pad1); end
        total++; if (mst_req0.ar.addr !== 32'hA5A5_0000 || slv_resp0.r.data !== 32'h1234_5678 || bus_slv.r_data !== 32'h1234_5678) begin bad++; $display("FAIL rsth_ar_r: got %h/%h want a5a50000/12345678", mst_req0.ar.addr, slv_resp0.r.data); end
        @(negedge clk);
        rst_ni = 1'b1;
        slv_req.aw_valid = 1'b0;
        slv_req.b_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (slv_resp0.b_valid || bus_slv.b_valid) replay++;
        end
        total++; if (replay != 0) begin bad++; $display("FAIL rsth_no_replay: got %0d want 0", replay); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_passthrough();
        test_pad10();
        test_dynamic();
        test_min_latency();
        test_pad_pulse();
        test_back_to_back();
        test_reset_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_pad_write.md
# axi_pad_write

Write-path latency padder for AXI4. Sits between an AXI master (slave port) and the memory system (master port). It forces every write response (B) to reach the slave port no earlier than a fixed number of cycles after its AW handshake, which removes write-latency timing channels. It serializes writes to one outstanding transaction. It is the write-direction companion of the read-path padder and uses the same pad-cycle programming convention.

## Interface
- PadCycles, 0: reset value of the pad target, in cycles from the AW handshake to B valid.
- PadDynamic, 0: when 1, the pad target grows to any longer measured write latency. Use only with homogeneous traffic.
- req_t, logic: AXI request struct.
- resp_t, logic: AXI response struct.
- b_chan_t, logic: AXI B channel payload struct.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- slv_req_i  in  req_t  request from the upstream master.
- slv_resp_o  out  resp_t  response to the upstream master.
- mst_req_o  out  req_t  request to downstream.
- mst_resp_i  in  resp_t  response from downstream.
- pad_cycles_i  in  32  new pad target. 32'hFFFF_FFFF means keep the current value.
- pad_cycles_o  out  32  current pad target (pad_cycles_q).

## Operation
- AR and R channels pass through combinationally, unmodified. W passes through unmodified (W before AW is legal). aw payload passes through.
- State machine, 2 bits: IDLE, BUSY, HOLD.
- IDLE
  - aw_valid and aw_ready pass through.
  - mst b_ready = 0; slv b_valid = 0; counter_q held at 0.
  - On AW handshake: counter_d = 1, go to BUSY.
- BUSY
  - AW is blocked: mst aw_valid = 0, slv aw_ready = 0.
  - mst b_ready = 1; slv b_valid = 0; counter increments.
  - On mst b_valid: capture the B payload into b_q, go to HOLD.
  - If PadDynamic and counter_q+1 > pad_cycles_q, then pad_cycles_d = counter_q+1.
- HOLD
  - AW is blocked; mst b_ready = 0; counter increments.
  - slv b_valid = (counter_q >= pad_cycles_q); slv b = b_q.
  - On slv b_valid && b_ready: go to IDLE, counter_d = 0.
- Counter is 32 bits and saturates at 32'hFFFF_FFFF. It never wraps.
- Each cycle, if pad_cycles_i != 32'hFFFF_FFFF, then pad_cycles_d = pad_cycles_i. This overrides the dynamic update. The new value takes effect immediately, including mid-transaction.
- Reset values:
  - state IDLE, counter 0, pad_cycles_q = PadCycles, b_q = '0.
  - slv b_valid = 0, mst b_ready = 0, pad_cycles_o = PadCycles.
  - aw_valid/aw_ready follow the IDLE pass-through.
- Reset mid-transaction drops the captured B. No response is replayed.

## Timing
- Let t be the AW handshake cycle. Let the downstream B handshake occur at t+L, L >= 1.
- slv b_valid first asserts at cycle t+max(P, L+1), where P is pad_cycles_q. Minimum added latency is one cycle (the b_q register).
- P = 0 or 1 gives the minimum latency L+1.
- B stays asserted with a stable payload until the slave-side handshake (AXI valid rule).
- A new AW is accepted no earlier than the cycle after the slave-side B handshake.
- Simultaneous AW valid and slv B handshake in HOLD: AW is not accepted that cycle.

## Structure
- Shared package axi_pad_pkg:
  - pad_state_e enum {IDLE, BUSY, HOLD}.
  - localparam PadKeep = 32'hFFFF_FFFF.
  - The read-side padder shares PadKeep.
- Sub-module: axi_pad_write_intf, an AXI_BUS.Slave/Master wrapper that maps interface signals to the req_t/resp_t structs (user fields tied to '0).
- Core RTL: one always_comb FSM plus one always_ff register process.

## Test plan
- P=10, downstream B at L=3 → slv b_valid at t+10 with the captured id/resp; pad_cycles_o stays 10.
- P=2, downstream L=7 → slv b_valid at t+8; with PadDynamic=1, pad_cycles_o becomes 8 after the capture cycle; with PadDynamic=0, it stays 2.
- Second AW asserted while in BUSY/HOLD → slv aw_ready = 0 and mst aw_valid = 0 until the cycle after the first B handshake; then the AW is accepted.
- Slave holds b_ready = 0 for 5 cycles in HOLD → b_valid and payload stay stable, counter keeps counting, and no AW is accepted.
- pad_cycles_i = 20 pulsed mid-BUSY with P=10 → B is delayed to t+20; pad_cycles_i = FFFF_FFFF thereafter keeps 20.
- rst_ni asserted in HOLD → next cycle slv b_valid = 0, state IDLE, pad_cycles_o = PadCycles; concurrent AR/R traffic passes unaffected.
